// File: rtl/tpu_pkg.sv
// Shared TPU definitions: bus widths common with the instruction decoder,
// the systolic array size, and the weight loader state encoding.
package tpu_pkg;

   localparam int ADDR_W  = 13;
   localparam int DATA_W  = 8;
   localparam int ARRAY_N = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } wl_state_e;

endpackage

// File: rtl/rd_latency_pipe.sv
// Valid-bit delay line matching the read latency of the unified buffer.
// o_valid rises exactly DEPTH cycles after i_valid, aligned with read data.
module rd_latency_pipe #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_valid,
   output logic o_valid
);

   logic [DEPTH-1:0] r_pipe;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         // Each stage takes the previous one; stage 0 takes the read strobe.
         always_ff @(posedge clk) begin
            if (!reset) begin
               r_pipe[gi] <= 1'b0;
            end else if (gi == 0) begin
               r_pipe[gi] <= i_valid;
            end else begin
               r_pipe[gi] <= r_pipe[(gi > 0) ? gi - 1 : 0];
            end
         end
      end
   endgenerate

   assign o_valid = r_pipe[DEPTH-1];

endmodule

// File: rtl/weight_loader.sv
// Weight tile loader: on a rising load_weight it reads an ARRAY_N x ARRAY_N
// tile from the unified buffer and writes it row by row into the systolic
// array weight registers, then pulses done. All outputs are registered.
module weight_loader #(
   parameter int ADDR_W      = tpu_pkg::ADDR_W,
   parameter int DATA_W      = tpu_pkg::DATA_W,
   parameter int ARRAY_N     = tpu_pkg::ARRAY_N,
   parameter int MEM_LATENCY = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        load_weight,
   input  logic [ADDR_W-1:0]           base_address,
   output logic                        mem_rd_en,
   output logic [ADDR_W-1:0]           mem_rd_addr,
   input  logic [DATA_W-1:0]           mem_rd_data,
   output logic                        weight_wr,
   output logic [$clog2(ARRAY_N)-1:0]  weight_row,
   output logic [ARRAY_N*DATA_W-1:0]   weight_data,
   output logic                        busy,
   output logic                        done
);

   import tpu_pkg::*;

   localparam int NN     = ARRAY_N * ARRAY_N;
   localparam int CNT_W  = $clog2(NN + 1);
   localparam int ROW_W  = $clog2(ARRAY_N);
   localparam int ROWD_W = ARRAY_N * DATA_W;

   wl_state_e         r_state, w_state_next;
   logic              r_load_q;
   logic [ADDR_W-1:0] r_addr_q, w_addr_q_next;
   logic [CNT_W-1:0]  r_issue_cnt, w_issue_cnt_next;
   logic [ROW_W-1:0]  r_col, w_col_next;
   logic [ROW_W-1:0]  r_row, w_row_next;
   logic [ROWD_W-1:0] r_row_buf, w_row_buf_next, w_row_merged;
   logic              r_mem_rd_en, w_mem_rd_en_next;
   logic [ADDR_W-1:0] r_mem_rd_addr, w_mem_rd_addr_next;
   logic              r_weight_wr, w_weight_wr_next;
   logic [ROW_W-1:0]  r_weight_row, w_weight_row_next;
   logic [ROWD_W-1:0] r_weight_data, w_weight_data_next;
   logic              r_busy, w_busy_next;
   logic              r_done, w_done_next;
   logic              w_start;
   logic              w_rd_valid;

   // Only a fresh rising edge seen while idle starts a load; others are dropped.
   assign w_start = (r_state == IDLE) && load_weight && !r_load_q;

   rd_latency_pipe #(
      .DEPTH (MEM_LATENCY)
   ) u_rd_pipe (
      .clk     (clk),
      .reset   (reset),
      .i_valid (r_mem_rd_en),
      .o_valid (w_rd_valid)
   );

   // State and output registers; reset aborts any load and drops partial rows.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_load_q      <= 1'b0;
         r_addr_q      <= '0;
         r_issue_cnt   <= '0;
         r_col         <= '0;
         r_row         <= '0;
         r_row_buf     <= '0;
         r_mem_rd_en   <= 1'b0;
         r_mem_rd_addr <= '0;
         r_weight_wr   <= 1'b0;
         r_weight_row  <= '0;
         r_weight_data <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_load_q      <= load_weight;
         r_addr_q      <= w_addr_q_next;
         r_issue_cnt   <= w_issue_cnt_next;
         r_col         <= w_col_next;
         r_row         <= w_row_next;
         r_row_buf     <= w_row_buf_next;
         r_mem_rd_en   <= w_mem_rd_en_next;
         r_mem_rd_addr <= w_mem_rd_addr_next;
         r_weight_wr   <= w_weight_wr_next;
         r_weight_row  <= w_weight_row_next;
         r_weight_data <= w_weight_data_next;
         r_busy        <= w_busy_next;
         r_done        <= w_done_next;
      end
   end

   // Next-state logic: read issue sequencing plus row assembly of returned data.
   always_comb begin
      w_state_next       = r_state;
      w_addr_q_next      = r_addr_q;
      w_issue_cnt_next   = r_issue_cnt;
      w_col_next         = r_col;
      w_row_next         = r_row;
      w_row_buf_next     = r_row_buf;
      w_mem_rd_en_next   = 1'b0;
      w_mem_rd_addr_next = r_mem_rd_addr;
      w_weight_wr_next   = 1'b0;
      w_weight_row_next  = r_weight_row;
      w_weight_data_next = r_weight_data;
      w_busy_next        = r_busy;
      w_done_next        = 1'b0;

      w_row_merged = r_row_buf;
      w_row_merged[r_col*DATA_W +: DATA_W] = mem_rd_data;

      // Returned word fills the next column; the last column emits the row.
      if (w_rd_valid) begin
         if (r_col == ROW_W'(ARRAY_N - 1)) begin
            w_weight_wr_next   = 1'b1;
            w_weight_row_next  = r_row;
            w_weight_data_next = w_row_merged;
            w_col_next         = '0;
            w_row_next         = r_row + ROW_W'(1);
         end else begin
            w_row_buf_next = w_row_merged;
            w_col_next     = r_col + ROW_W'(1);
         end
      end

      case (r_state)
         IDLE: begin
            if (w_start) begin
               // First read goes out together with the start so the
               // strobe appears in the cycle right after start.
               w_addr_q_next      = base_address;
               w_issue_cnt_next   = CNT_W'(1);
               w_col_next         = '0;
               w_row_next         = '0;
               w_row_buf_next     = '0;
               w_mem_rd_en_next   = 1'b1;
               w_mem_rd_addr_next = base_address;
               w_busy_next        = 1'b1;
               w_state_next       = FETCH;
            end
         end
         FETCH: begin
            if (r_issue_cnt == CNT_W'(NN)) begin
               w_state_next = DRAIN;
            end else begin
               w_mem_rd_en_next   = 1'b1;
               w_mem_rd_addr_next = r_addr_q + ADDR_W'(r_issue_cnt);
               w_issue_cnt_next   = r_issue_cnt + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (r_weight_wr && (r_weight_row == ROW_W'(ARRAY_N - 1))) begin
               w_done_next  = 1'b1;
               w_busy_next  = 1'b0;
               w_state_next = DONE;
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign mem_rd_en   = r_mem_rd_en;
   assign mem_rd_addr = r_mem_rd_addr;
   assign weight_wr   = r_weight_wr;
   assign weight_row  = r_weight_row;
   assign weight_data = r_weight_data;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: two instances (read latency 1 and 3) share one
// stimulus stream and one memory image; a timing/data reference model derived
// from the load timeline formulas predicts every output on every cycle.
module tb_weight_loader;

   localparam int AW = 13;
   localparam int DW = 8;
   localparam int N  = 2;
   localparam int NN = N * N;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          load_weight;
   logic [AW-1:0] base_address;

   logic           en    [2];
   logic [AW-1:0]  addr  [2];
   logic [DW-1:0]  rdata [2];
   logic           wr    [2];
   logic [0:0]     wrow  [2];
   logic [N*DW-1:0] wdata [2];
   logic           busy  [2];
   logic           done  [2];

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] mb0, mb1;

   int lat [2] = '{1, 3};

   int n_tests = 0;
   int n_fail  = 0;

   weight_loader #(.ADDR_W(AW), .DATA_W(DW), .ARRAY_N(N), .MEM_LATENCY(1)) u_dut_l1 (
      .clk(clk), .reset(reset), .load_weight(load_weight), .base_address(base_address),
      .mem_rd_en(en[0]), .mem_rd_addr(addr[0]), .mem_rd_data(rdata[0]),
      .weight_wr(wr[0]), .weight_row(wrow[0]), .weight_data(wdata[0]),
      .busy(busy[0]), .done(done[0]));

   weight_loader #(.ADDR_W(AW), .DATA_W(DW), .ARRAY_N(N), .MEM_LATENCY(3)) u_dut_l3 (
      .clk(clk), .reset(reset), .load_weight(load_weight), .base_address(base_address),
      .mem_rd_en(en[1]), .mem_rd_addr(addr[1]), .mem_rd_data(rdata[1]),
      .weight_wr(wr[1]), .weight_row(wrow[1]), .weight_data(wdata[1]),
      .busy(busy[1]), .done(done[1]));

   // Unified buffer, latency 1: data registered on the edge after the strobe.
   always @(posedge clk) begin
      if (en[0]) rdata[0] <= mem[addr[0]];
   end

   // Unified buffer, latency 3: address sampled every cycle, three stages deep.
   always @(posedge clk) begin
      mb0      <= mem[addr[1]];
      mb1      <= mb0;
      rdata[1] <= mb1;
   end

   // Reference model state: one active load per instance.
   int            cyc = 0;
   logic          lw_prev = 1'b0;
   int            m_active [2] = '{0, 0};
   int            m_s      [2] = '{0, 0};
   logic [AW-1:0] m_b      [2];
   logic [N*DW-1:0] m_data [2];
   logic [0:0]    m_row    [2];

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut_l%0d cyc=%0d observed=%0h expected=%0h", tag, lat[d], cyc, obs, exp);
      end
   endtask

   // Advance one clock and compare both instances against the model.
   task automatic step();
      logic          rst_s, lw_s;
      logic [AW-1:0] b_s;
      rst_s = reset;
      lw_s  = load_weight;
      b_s   = base_address;
      for (int d = 0; d < 2; d++) begin
         if (!rst_s) begin
            m_active[d] = 0;
            m_data[d]   = '0;
            m_row[d]    = '0;
         end else if (lw_s && !lw_prev &&
                      (m_active[d] == 0 || cyc >= m_s[d] + NN + lat[d] + 3)) begin
            m_active[d] = 1;
            m_s[d]      = cyc;
            m_b[d]      = b_s;
         end
      end
      lw_prev = rst_s ? lw_s : 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         int            t;
         logic          e_en, e_wr, e_busy, e_done;
         logic [AW-1:0] e_addr;
         t      = cyc - m_s[d];
         e_en   = (m_active[d] != 0) && t >= 1 && t <= NN;
         e_addr = m_b[d] + AW'(t - 1);
         e_busy = (m_active[d] != 0) && t >= 1 && t <= NN + lat[d] + 1;
         e_done = (m_active[d] != 0) && t == NN + lat[d] + 2;
         e_wr   = 1'b0;
         for (int r = 0; r < N; r++) begin
            if (m_active[d] != 0 && t == lat[d] + 1 + N * (r + 1)) begin
               e_wr     = 1'b1;
               m_row[d] = 1'(r);
               for (int c = 0; c < N; c++)
                  m_data[d][c*DW +: DW] = mem[m_b[d] + AW'(r * N + c)];
            end
         end
         chk("rd_en", d, 32'(en[d]), 32'(e_en));
         if (e_en) chk("rd_addr", d, 32'(addr[d]), 32'(e_addr));
         chk("weight_wr", d, 32'(wr[d]), 32'(e_wr));
         chk("weight_row", d, 32'(wrow[d]), 32'(m_row[d]));
         chk("weight_data", d, 32'(wdata[d]), 32'(m_data[d]));
         chk("busy", d, 32'(busy[d]), 32'(e_busy));
         chk("done", d, 32'(done[d]), 32'(e_done));
         if (e_done)
            $display("[TB] dut_l%0d load base=%0d completed at cycle %0d", lat[d], m_b[d], cyc);
      end
   endtask

   task automatic pulse_load(input logic [AW-1:0] b, input int tail);
      base_address = b;
      load_weight  = 1'b1;
      step();
      load_weight  = 1'b0;
      for (int i = 0; i < tail; i++) begin
         base_address = AW'($urandom);
         step();
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
      mem[100] = 8'h11; mem[101] = 8'h22; mem[102] = 8'h33; mem[103] = 8'h44;
      reset = 1'b0; load_weight = 1'b0; base_address = '0;

      // Reset state.
      step(); step();
      reset = 1'b1;
      step();

      // Basic load from 100 (rows 0x2211, 0x4433), base scrambled afterwards.
      pulse_load(AW'(100), 12);
      chk("basic_row1_data", 0, 32'(wdata[0]), 32'h4433);

      // Held level: exactly one load over 20 cycles.
      base_address = AW'($urandom);
      load_weight  = 1'b1;
      for (int i = 0; i < 20; i++) step();
      load_weight = 1'b0;
      step(); step();

      // Rising edge while busy is ignored and does not disturb addresses.
      base_address = AW'(500);
      load_weight  = 1'b1; step();
      load_weight  = 1'b0; step();
      base_address = AW'(900);
      load_weight  = 1'b1; step();
      load_weight  = 1'b0;
      for (int i = 0; i < 12; i++) step();

      // Address wrap at the top of the buffer.
      pulse_load(AW'(8190), 12);

      // Reset in cycle 3 of a load, then a clean load.
      pulse_load(AW'($urandom), 3);
      reset = 1'b0; step();
      reset = 1'b1; step(); step();
      pulse_load(AW'($urandom), 12);

      // Level already high when reset releases counts as a rising edge.
      reset = 1'b0; load_weight = 1'b1; base_address = AW'(300);
      step(); step();
      reset = 1'b1; step();
      load_weight = 1'b0;
      for (int i = 0; i < 12; i++) step();

      // Back-to-back: new edge in the cycle after done, new base sampled there.
      pulse_load(AW'(40), 0);
      begin
         int k = 0;
         while (done[0] !== 1'b1 && k < 20) begin step(); k++; end
         chk("done_wait", 0, 32'(done[0]), 32'd1);
      end
      step();
      pulse_load(AW'(4000), 14);

      // Random loads with base disturbed after each start.
      for (int j = 0; j < 6; j++) pulse_load(AW'($urandom), $urandom_range(10, 14));
      for (int i = 0; i < 4; i++) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
